// File: rtl/rr_stream_mux.sv
// N:1 stream selector with a registered output stage. It picks a channel either from an
// external select (fixed mode) or from a rotating round-robin pointer.
module rr_stream_mux #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CH    = 4,
  parameter int unsigned SELW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic [SELW-1:0]   sel,
  input  logic [CH-1:0]     in_valid,
  input  logic [CH*WIDTH-1:0] in_data,
  output logic [CH-1:0]     in_ready,
  output logic              out_valid,
  output logic [WIDTH-1:0]  out_data,
  output logic [SELW-1:0]   out_ch,
  input  logic              out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_ch_q, out_ch_d;
  logic [SELW-1:0]  ptr_q, ptr_d;

  logic             load_en;
  logic             gnt_vld;
  logic [SELW-1:0]  gnt_idx;
  logic             xfer;

  assign load_en = !out_valid_q || out_ready;

  // Grant: fixed mode honours only sel; round-robin scans ptr+1 .. ptr+CH modulo CH.
  always_comb begin
    int unsigned idx;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    if (!mode) begin
      if ((32'(sel) < CH) && in_valid[sel]) begin
        gnt_vld = 1'b1;
        gnt_idx = sel;
      end
    end else begin
      for (int unsigned k = 1; k <= CH; k++) begin
        idx = (32'(ptr_q) + k) % CH;
        if (!gnt_vld && in_valid[SELW'(idx)]) begin
          gnt_vld = 1'b1;
          gnt_idx = SELW'(idx);
        end
      end
    end
  end

  assign xfer = gnt_vld && load_en;

  always_comb begin
    in_ready = '0;
    if (xfer && !rst) begin
      in_ready[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (load_en) begin
      out_valid_d = gnt_vld;
      if (gnt_vld) begin
        out_data_d = in_data[gnt_idx*WIDTH +: WIDTH];
        out_ch_d   = gnt_idx;
        ptr_d      = gnt_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= SELW'(CH - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: doc/rr_stream_mux.md
Name: rr_stream_mux

Overview:
- Parametrised successor to the team's 4:1 8-bit selector.
- Selects one of CH input channels of WIDTH bits onto a single registered output stream, using per-channel valid/ready handshakes.
- Two modes:
  - Fixed mode: an external select picks the channel.
  - Round-robin mode: a fair rotating arbiter picks the channel.
- Sits between multiple producers and one shared consumer, such as a shared display or bus port.

Parameters:
- WIDTH, 8, data width per channel.
- CH, 4, number of input channels (2..16).
- SELW, 2, channel index width; must equal clog2(CH).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- mode  input  1  0 = fixed select via sel; 1 = round-robin.
- sel  input  SELW  channel selected in fixed mode.
- in_valid  input  CH  bit i = channel i offers data.
- in_data  input  CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  CH  bit i = channel i's data is accepted this cycle.
- out_valid  output  1  output register holds valid data.
- out_data  output  WIDTH  registered data.
- out_ch  output  SELW  index of the channel that supplied out_data.
- out_ready  input  1  consumer accepts out_data this cycle.

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_data=0, out_ch=0.
  - Round-robin pointer ptr=CH-1, so the first search starts at channel 0.
  - in_ready forced to all-zero while rst=1.
- load_en = !out_valid || out_ready. The output register may load when empty or when being drained the same cycle.
- Grant, combinational:
  - mode=0: grant = sel if in_valid[sel]=1, else no grant. Other channels are never granted, even if valid.
  - mode=1: grant = first i with in_valid[i]=1, scanning ptr+1, ptr+2, ... modulo CH, wrapping CH-1 -> 0. No grant if in_valid=0.
- in_ready:
  - One-hot or zero.
  - in_ready[grant]=1 only when load_en=1 and a grant exists.
  - in_ready never depends on out_valid of the same channel beyond load_en.
- Transfer on channel g occurs when in_valid[g] && in_ready[g] at a rising clk edge. Next cycle:
  - out_valid=1.
  - out_data = in_data[g*WIDTH +: WIDTH].
  - out_ch = g.
  - ptr = g, updated in both modes.
- If load_en=1 and no grant: out_valid<=0; out_data and out_ch hold their old values.
- Stall: while out_valid=1 and out_ready=0, out_data, out_ch and out_valid are stable and in_ready is all-zero.
- Latency: input accept to out_valid is 1 clock.
- Throughput: one word per clock when out_ready is held high.
- Simultaneous drain and load: the old word leaves and the new word is loaded at the same edge. No bubble, no loss.
- Fairness in mode 1: with all CH channels continuously valid and out_ready=1, grants cycle 0,1,...,CH-1,0,... Each channel is served once per CH transfers.
- Mode or sel change:
  - Affects only the grant computed in the current cycle.
  - A held output word is never altered.
  - ptr is not reset by a mode change.
- Producers must hold in_data stable while in_valid=1 and in_ready=0. The block does not check this.
- Reset mid-stall discards the held word: out_valid=0 immediately on rst assertion.
- No combinational path from out_ready to out_data. A path from out_ready to in_ready is permitted.

Test Plan:
- Reset check:
  - Stimulus: assert rst with in_valid=4'b1111, then release.
  - Required: during rst, out_valid=0, out_data=8'h00, out_ch=0, in_ready=4'b0000.
- Fixed-mode sweep:
  - Stimulus: mode=0; in_data channels 0..3 = 8'h00, 8'h0F, 8'hF0, 8'hFF, all valid; out_ready=1; sel stepped 00,01,10,11.
  - Required: one cycle after each step, out_data = 00, 0F, F0, FF and out_ch = sel.
- Fixed mode, unselected valid:
  - Stimulus: mode=0, sel=2, in_valid=4'b1011.
  - Required: in_ready=0000, out_valid falls to 0, channels 0, 1 and 3 never granted.
- Round-robin fairness:
  - Stimulus: mode=1, all valid, out_ready=1 for 8 cycles.
  - Required: out_ch sequence 0,1,2,3,0,1,2,3.
  - Stimulus: then in_valid=4'b1010.
  - Required: out_ch alternates 1,3,1,3.
- Backpressure:
  - Stimulus: mode=1, out_ready=0 for 3 cycles after the first word (ch0, 8'h00).
  - Required: out_data stays 8'h00 and in_ready=0000 during the stall.
  - Stimulus: release out_ready.
  - Required: next word is ch1 8'h0F on the following cycle, with no word dropped or duplicated.
- Reset mid-stall:
  - Stimulus: assert rst asynchronously while out_valid=1, out_ready=0.
  - Required: out_valid=0 before the next clk edge. After release in mode 1, the first grant is channel 0.
